// File: rtl/mac_pkg.sv
// Shared types and widths for the 2x3 signed multiply-accumulate stage.
package mac_pkg;
    localparam int A_W       = 2;
    localparam int B_W       = 3;
    localparam int PROD_W    = 5;
    localparam int ACC_W_DEF = 12;
    localparam int LEN_W_DEF = 4;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    typedef struct packed {
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
    } op_t;
endpackage

// File: rtl/Mult_2_3.sv
// Combinational signed 2-bit x signed 3-bit multiplier with a 5-bit product.
module Mult_2_3 (
    input  logic [1:0] IN1,
    input  logic [2:0] IN2,
    output logic [4:0] Out
);
    logic signed [4:0] x1, x2;

    assign x1  = {{3{IN1[1]}}, IN1};
    assign x2  = {{2{IN2[2]}}, IN2};
    assign Out = x1 * x2;
endmodule

// File: rtl/mac_2_3_acc.sv
// Burst multiply-accumulate: registered operands feed Mult_2_3, products are
// summed into a wrapping accumulator with a sticky signed-overflow flag.
module mac_2_3_acc
    import mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [A_W-1:0]   a_i,
    input  logic [B_W-1:0]   b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] acc_out_o,
    output logic             ovf_o
);
    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d, cnt_inc;
    op_t                op_q, op_d;
    logic               s1_vld_q, s1_vld_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;

    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   prod_ext, sum;
    logic               add_ovf, accept;

    Mult_2_3 u_mult (
        .IN1 (op_q.a),
        .IN2 (op_q.b),
        .Out (prod)
    );

    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign sum      = acc_q + prod_ext;
    // Signed overflow: like-signed operands yielding an opposite-signed sum.
    assign add_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);

    assign in_ready_o  = (state_q == RUN);
    assign out_valid_o = (state_q == DONE);
    assign acc_out_o   = acc_q;
    assign ovf_o       = ovf_q;
    assign accept      = in_valid_i && in_ready_o;
    assign cnt_inc     = cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        s1_vld_d = accept;

        if (s1_vld_q) begin
            acc_d = sum;
            if (add_ovf) ovf_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (len_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    op_d  = '{a: a_i, b: b_i};
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) state_d = FLUSH;
                end
            end
            FLUSH: state_d = DONE;
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            s1_vld_q <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            s1_vld_q <= s1_vld_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mac_2_3_acc.sv
// Scoreboard bench: two DUTs (ACC_W=12 and ACC_W=6) share one stimulus stream.
module tb_mac_2_3_acc;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, in_valid, out_ready;
    logic [3:0] len;
    logic [1:0] a;
    logic [2:0] b;
    logic       in_ready, out_valid, ovf;
    logic       in_ready6, out_valid6, ovf6;
    logic [11:0] acc;
    logic [5:0]  acc6;

    mac_2_3_acc #(.ACC_W(12), .LEN_W(4)) dut12 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .a_i(a), .b_i(b),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .acc_out_o(acc), .ovf_o(ovf));

    mac_2_3_acc #(.ACC_W(6), .LEN_W(4)) dut6 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
        .in_valid_i(in_valid), .in_ready_o(in_ready6), .a_i(a), .b_i(b),
        .out_valid_o(out_valid6), .out_ready_i(out_ready),
        .acc_out_o(acc6), .ovf_o(ovf6));

    typedef struct {
        int acc12;
        int ovf12;
        int acc6;
        int ovf6;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ta[16];
    int   tb[16];
    logic prev_ov = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Running sum of true products, with overflow judged against the W-bit signed range.
    task automatic model(input int n, input int w, output int v_out, output int o);
        int m, v, s;
        m = 1 << w;
        v = 0;
        o = 0;
        for (int i = 0; i < n; i++) begin
            s = v + ta[i] * tb[i];
            if (s > m / 2 - 1 || s < -(m / 2)) o = 1;
            v = ((s % m) + m) % m;
            if (v >= m / 2) v -= m;
        end
        v_out = ((v % m) + m) % m;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: out_valid with empty scoreboard at %0t", $time);
                end else begin
                    cur = sbq.pop_front();
                end
            end
            if (out_valid) begin
                chk("acc12", int'(acc), cur.acc12);
                chk("ovf12", int'(ovf), cur.ovf12);
                chk("acc6", int'(acc6), cur.acc6);
                chk("ovf6", int'(ovf6), cur.ovf6);
                chk("out_valid6", int'(out_valid6), 1);
                chk("done_in_ready", int'(in_ready), 0);
            end
            prev_ov = out_valid;
        end
    end

    task automatic burst(input int n, input int bub, input int hold, input bit start_in_done);
        exp_t e;
        int   i, guard;
        bit   acc_now;
        model(n, 12, e.acc12, e.ovf12);
        model(n, 6, e.acc6, e.ovf6);
        @(posedge clk); #1;
        start = 1'b1;
        len   = 4'(n);
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        if (n == 0) begin
            chk("len0_in_ready", int'(in_ready), 0);
            chk("len0_out_valid", int'(out_valid), 1);
        end else begin
            chk("run_in_ready", int'(in_ready), 1);
            i = 0;
            guard = 0;
            while (i < n && guard < 1000) begin
                guard++;
                if (int'($urandom_range(99)) < bub) begin
                    in_valid = 1'b0;
                    a = 2'($urandom);
                    b = 3'($urandom);
                end else begin
                    in_valid = 1'b1;
                    a = 2'(ta[i]);
                    b = 3'(tb[i]);
                end
                @(negedge clk);
                acc_now = in_valid && in_ready;
                @(posedge clk); #1;
                if (acc_now) i++;
            end
            if (guard >= 1000) chk("accept_timeout", i, n);
            in_valid = 1'b0;
            a = 2'($urandom);
            b = 3'($urandom);
            chk("flush_in_ready", int'(in_ready), 0);
            chk("flush_out_valid", int'(out_valid), 0);
            @(posedge clk); #1;
            chk("done_out_valid", int'(out_valid), 1);
        end
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = (start_in_done && h == 1);
            @(posedge clk); #1;
            chk("hold_out_valid", int'(out_valid), 1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_in_ready", int'(in_ready), 0);
    endtask

    task automatic reset_midburst();
        @(posedge clk); #1;
        start = 1'b1;
        len = 4'd5;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            a = 2'($urandom_range(1));
            b = 3'($urandom_range(3));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_acc", int'(acc), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_acc6", int'(acc6), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        len = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", int'(in_ready), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_acc", int'(acc), 0);
        chk("reset_ovf", int'(ovf), 0);
        rst = 1'b0;

        ta[0] = 1;  tb[0] = 3;
        ta[1] = -2; tb[1] = -4;
        ta[2] = 1;  tb[2] = -1;
        burst(3, 0, 0, 1'b0);

        burst(0, 0, 2, 1'b0);

        for (int k = 0; k < 4; k++) begin ta[k] = 1; tb[k] = 1; end
        burst(4, 50, 5, 1'b1);

        for (int k = 0; k < 8; k++) begin ta[k] = -2; tb[k] = -4; end
        burst(8, 0, 1, 1'b0);

        reset_midburst();
        ta[0] = 1; tb[0] = -4;
        burst(1, 0, 0, 1'b0);

        for (int av = -2; av <= 1; av++) begin
            for (int bv = -4; bv <= 3; bv++) begin
                ta[0] = av; tb[0] = bv;
                burst(1, 0, 0, 1'b0);
            end
        end

        for (int r = 0; r < 30; r++) begin
            int n;
            n = (r % 10 == 9) ? 0 : int'($urandom_range(15, 1));
            for (int k = 0; k < 16; k++) begin
                ta[k] = int'($urandom_range(3)) - 2;
                tb[k] = int'($urandom_range(7)) - 4;
            end
            burst(n, int'($urandom_range(60)), int'($urandom_range(3)), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mac_2_3_acc.md
# mac_2_3_acc

Sequential multiply-accumulate stage directly downstream of the existing Mult_2_3 combinational multiplier. It accepts a burst of signed 2-bit × signed 3-bit operand pairs over a valid/ready handshake. Each pair is multiplied through one Mult_2_3 instance, and the sign-extended 5-bit products are summed into an ACC_W-bit accumulator. At the end of the burst it presents the sum and a sticky overflow flag on an output valid/ready handshake.

## Interface
- ACC_W, 12, accumulator and result width in bits; must be ≥ 5.
- LEN_W, 4, width of the burst-length field; maximum burst is 2^LEN_W − 1 terms.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- len  input  LEN_W  number of terms in the burst, unsigned; latched with start.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  stage accepts an operand pair this cycle.
- a  input  2  multiplicand, two's complement (−2..1).
- b  input  3  multiplier, two's complement (−4..3).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- acc_out  output  ACC_W  accumulated sum, two's complement.
- ovf  output  1  sticky signed-overflow flag for the current burst.

## Operation
- States are IDLE, RUN, FLUSH and DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 latches len, clears the accumulator, ovf and the term counter.
  - If len=0, go to DONE. Otherwise go to RUN.
- RUN:
  - in_ready=1.
  - Each accept (in_valid&&in_ready) loads a and b into the stage-1 operand register, sets stage1_valid and increments the counter.
  - An accept that brings the counter to len moves the FSM to FLUSH.
  - Cycles with in_valid=0 are bubbles and leave everything unchanged.
- Accumulate step:
  - Every cycle stage1_valid=1, the Mult_2_3 product of the registered operands is used.
  - The product is treated as 5-bit two's complement, sign-extended to ACC_W, and added to the accumulator (mod 2^ACC_W).
  - stage1_valid clears unless a new accept occurs in the same cycle.
- Overflow: ovf is set when the add has signed overflow (both operands have the same sign and the sum has the opposite sign). ovf stays set until the next start.
- FLUSH:
  - in_ready=0.
  - The final product is added in this cycle, then the FSM goes to DONE.
- DONE:
  - out_valid=1. acc_out and ovf are held stable.
  - out_valid&&out_ready moves the FSM to IDLE. out_valid may stay high indefinitely.
- start is ignored in RUN, FLUSH and DONE.
- a, b and in_valid are ignored whenever in_ready=0.
- acc_out reflects the accumulator register in all states. It is meaningful only while out_valid=1.

## Timing
- Reset clears everything: state=IDLE, in_ready=0, out_valid=0, acc_out=0, ovf=0, stage1_valid=0, counter=0.
- Reset mid-burst abandons the burst. Outputs take their reset values on the cycle after rst is sampled high.
- start sampled at cycle 0:
  - len≠0: RUN and in_ready=1 from cycle 1.
  - len=0: out_valid=1 at cycle 1 with acc_out=0.
- Last accept at cycle t: FLUSH at t+1, out_valid=1 at t+2 with the final sum.
- Accept-to-accumulator-update latency is 2 cycles.
- Throughput is one term per cycle.
- Output accepted at cycle u: IDLE at u+1; a start at u+1 is honoured.
- Back-to-back bursts: the minimum gap from out_valid&&out_ready to the next in_ready is 2 cycles.

## Structure
- Package mac_pkg holds:
  - the state enum (IDLE, RUN, FLUSH, DONE);
  - PROD_W=5, A_W=2, B_W=3;
  - default ACC_W and LEN_W.
- One sub-module instance: the existing Mult_2_3, with IN1=a_q and IN2=b_q; its Out is the 5-bit product.
- All registers, the FSM and the adder with overflow detection live in mac_2_3_acc.

## Test plan
- len=3, pairs (1,3), (−2,−4), (1,−1) with no bubbles → out_valid 2 cycles after the third accept; acc_out=10, ovf=0.
- start with len=0 → out_valid=1 the next cycle; acc_out=0, ovf=0; in_ready never asserts.
- len=4, pairs (1,1) ×4 with in_valid bubbles between terms and out_ready held 0 for 5 cycles in DONE:
  - acc_out=4, held stable the whole time;
  - in_ready=0 and a start pulse during DONE is ignored.
- ACC_W=6, len=8, all pairs (−2,−4):
  - ovf sets on the 4th add (24+8);
  - final acc_out=0 (64 mod 64), ovf=1 at DONE.
- rst asserted in RUN after 2 accepts → next cycle all outputs are 0 and the state is IDLE; then start len=1 with pair (1,−4) → acc_out = −4 (0xFFC for ACC_W=12).
- Exhaustive: len=1 for each of the 32 (a,b) pairs → acc_out equals the sign-extended a×b (range −6..8), ovf=0.
